// File: rtl/spi_pkg.sv
// Shared SPI definitions: target FSM state type and link-wide constants
// (CPOL=1, CPHA=0, 8-bit frames) used by both ends of the SPI link.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT    = 3'd2,
        DONE     = 3'd3,
        WAIT_END = 3'd4
    } spi_tgt_state_e;

    localparam int SPI_CPOL = 1;
    localparam int SPI_CPHA = 0;
    localparam int SPI_BITS = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser plus edge detector for one asynchronous SPI pin.
// Ports: clk, rst_n, din (async pin) -> dout (synced), rise, fall (1-clk pulses).
module spi_sync_edge #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_q;
    logic         prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {N{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[N-2:0], din};
            prev_q <= sync_q[N-1];
        end
    end

    assign dout = sync_q[N-1];
    assign rise = ~prev_q & dout;
    assign fall = prev_q & ~dout;

endmodule

// File: rtl/spi_target.sv
// SPI target (CPOL=1, CPHA=0, MSB first), fully oversampled in the clk domain.
// Ports: SPI_CLK/SPI_EN/SPI_MOSI in, SPI_MISO out; tx_data/tx_valid/tx_ready
// one-entry holding buffer; rx_data/rx_valid per-frame strobe; busy.
// Optional macro SPI_TARGET_ERR_EN adds err_underrun and err_abort pulses.
module spi_target
    import spi_pkg::*;
#(
    parameter int              BITS        = SPI_BITS,
    parameter int              SYNC_STAGES = 2,
    parameter logic [BITS-1:0] IDLE_TX     = {BITS{1'b1}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            SPI_CLK,
    input  logic            SPI_EN,
    input  logic            SPI_MOSI,
    output logic            SPI_MISO,
    input  logic [BITS-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic [BITS-1:0] rx_data,
    output logic            rx_valid,
    output logic            busy
`ifdef SPI_TARGET_ERR_EN
    ,
    output logic            err_underrun,
    output logic            err_abort
`endif
);

    localparam int CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);
    localparam logic [CW-1:0] ALL_BITS = CW'(BITS);

    spi_tgt_state_e  state;
    logic [BITS-1:0] buf_q;
    logic            buf_full;
    logic [BITS-1:0] shift_tx;
    logic [BITS-1:0] shift_rx;
    logic [CW-1:0]   bit_cnt;

    logic sclk_q, sclk_rise, sclk_fall;
    logic en_q, en_rise, en_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic clk_rise, clk_fall, abort, accept;
    logic unused_sync;

    // Idle-high pins reset high so reset release creates no false edges.
    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .din(SPI_CLK),
        .dout(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
        .clk(clk), .rst_n(rst_n), .din(SPI_EN),
        .dout(en_q), .rise(en_rise), .fall(en_fall)
    );

    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(SPI_MOSI),
        .dout(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sclk_q, mosi_rise, mosi_fall};

    // Clock edges only count while the frame select is low.
    assign clk_rise = sclk_rise & ~en_q;
    assign clk_fall = sclk_fall & ~en_q;
    assign abort    = en_rise & ((state == LOAD) | (state == SHIFT));

    // LOAD drains the buffer this cycle, so a new byte may land alongside it.
    assign tx_ready = ~buf_full | (state == LOAD);
    assign accept   = tx_valid & tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            buf_q    <= '0;
            buf_full <= 1'b0;
            shift_tx <= '0;
            shift_rx <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                buf_q    <= tx_data;
                buf_full <= 1'b1;
            end else if (state == LOAD) begin
                buf_full <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (en_fall) state <= LOAD;
                end
                LOAD: begin
                    shift_tx <= buf_full ? buf_q : IDLE_TX;
                    shift_rx <= '0;
                    bit_cnt  <= '0;
                    state    <= en_rise ? IDLE : SHIFT;
                end
                SHIFT: begin
                    if (en_rise) begin
                        state <= IDLE;
                    end else if (clk_fall) begin
                        shift_rx <= {shift_rx[BITS-2:0], mosi_q};
                        bit_cnt  <= bit_cnt + CW'(1);
                        if (bit_cnt == LAST_BIT) state <= DONE;
                    end else if (clk_rise && bit_cnt != ALL_BITS) begin
                        shift_tx <= shift_tx << 1;
                    end
                end
                DONE: begin
                    rx_data  <= shift_rx;
                    rx_valid <= 1'b1;
                    state    <= en_rise ? IDLE : WAIT_END;
                end
                WAIT_END: begin
                    if (en_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MISO is driven from the shifter once loaded and held until deselect.
    assign SPI_MISO = ((state == SHIFT) | (state == DONE) | (state == WAIT_END))
                      ? shift_tx[BITS-1] : 1'b0;
    assign busy     = (state != IDLE);

`ifdef SPI_TARGET_ERR_EN
    assign err_underrun = (state == LOAD) & ~buf_full;
    assign err_abort    = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed frames plus random frames
// compared against a frame-level model of the tx buffer and rx path.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b1;
    logic       en = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    wire        miso;
    wire        tx_ready;
    wire  [7:0] rx_data;
    wire        rx_valid;
    wire        busy;
`ifdef SPI_TARGET_ERR_EN
    wire        err_underrun;
    wire        err_abort;
`endif

    spi_target dut (
        .clk(clk), .rst_n(rst_n),
        .SPI_CLK(sclk), .SPI_EN(en), .SPI_MOSI(mosi), .SPI_MISO(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_TARGET_ERR_EN
        , .err_underrun(err_underrun), .err_abort(err_abort)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rxv_cnt = 0;
    int und_cnt = 0;
    int abt_cnt = 0;

    // Frame-level model: one-entry buffer and last good rx byte.
    logic       m_full = 1'b0;
    logic [7:0] m_buf  = 8'h00;
    logic [7:0] m_rx   = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
`ifdef SPI_TARGET_ERR_EN
        if (err_underrun) und_cnt++;
        if (err_abort) abt_cnt++;
`endif
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_push(input logic [7:0] d);
        if (!m_full) begin
            m_buf  = d;
            m_full = 1'b1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        chk("push_ready", {31'd0, ok}, 32'd1);
    endtask

    task automatic frame_start();
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
    endtask

    task automatic shift_bits(input logic [7:0] data, input int n,
                              output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = data[7-i];
            repeat (10) @(negedge clk);
            got  = {got[6:0], miso};
            sclk = 1'b0;
            repeat (10) @(negedge clk);
            sclk = 1'b1;
        end
    endtask

    task automatic frame_end();
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] mo);
        logic [7:0] exp_mi, mi;
        int rx0, und0, exp_und;
        exp_mi  = m_full ? m_buf : 8'hFF;
        exp_und = m_full ? 0 : 1;
        m_full  = 1'b0;
        rx0     = rxv_cnt;
        und0    = und_cnt;
        frame_start();
        shift_bits(mo, 8, mi);
        frame_end();
        m_rx = mo;
        chk({tag, "_miso"}, {24'd0, mi}, {24'd0, exp_mi});
        chk({tag, "_rxdata"}, {24'd0, rx_data}, {24'd0, mo});
        chk({tag, "_rxvalid"}, rxv_cnt - rx0, 1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
`ifdef SPI_TARGET_ERR_EN
        chk({tag, "_under"}, und_cnt - und0, exp_und);
`endif
    endtask

    initial begin
        logic [7:0] got;
        int         rx0, abt0;

        repeat (3) @(negedge clk);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_txready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rxdata", {24'd0, rx_data}, 32'd0);
        chk("rst_rxvalid", {31'd0, rx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Loaded byte out, MOSI byte in.
        push(8'hA5);
        m_push(8'hA5);
        run_frame("t1", 8'h3C);

        // Underrun sends the idle pattern.
        run_frame("t2", 8'h00);

        // Abort after four bits.
        push(8'h77);
        m_push(8'h77);
        m_full = 1'b0;
        rx0  = rxv_cnt;
        abt0 = abt_cnt;
        frame_start();
        shift_bits(8'hF0, 4, got);
        frame_end();
        chk("t3_rxvalid", rxv_cnt - rx0, 0);
        chk("t3_rxdata", {24'd0, rx_data}, {24'd0, m_rx});
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_txready", {31'd0, tx_ready}, 32'd1);
`ifdef SPI_TARGET_ERR_EN
        chk("t3_abort", abt_cnt - abt0, 1);
`endif
        chk("t3_miso_part", {28'd0, got[3:0]}, 32'h7);

        // New byte offered while the buffer is full is taken in LOAD.
        push(8'h22);
        m_push(8'h22);
        fork
            run_frame("t4a", 8'h5A);
            push(8'h11);
        join
        m_buf  = 8'h11;
        m_full = 1'b1;
        chk("t4_txready", {31'd0, tx_ready}, 32'd0);
        run_frame("t4b", 8'hA7);

        // Back-to-back frames with the second byte refilled mid-frame.
        push(8'hC3);
        m_push(8'hC3);
        fork
            run_frame("t5a", 8'h01);
            begin
                repeat (40) @(negedge clk);
                push(8'h3C);
                m_push(8'h3C);
            end
        join
        run_frame("t5b", 8'h80);

        // Asynchronous reset at bit five.
        frame_start();
        push(8'h99);
        shift_bits(8'h6B, 5, got);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_miso", {31'd0, miso}, 32'd0);
        chk("t6_txready", {31'd0, tx_ready}, 32'd1);
        chk("t6_rxdata", {24'd0, rx_data}, 32'd0);
        chk("t6_rxvalid", {31'd0, rx_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        sclk = 1'b1;
        en   = 1'b1;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst_n  = 1'b1;
        m_full = 1'b0;
        m_rx   = 8'h00;
        repeat (5) @(negedge clk);
        push(8'h5E);
        m_push(8'h5E);
        run_frame("t6_after", 8'hB4);

        // Random frames, with ignored offers while the buffer is full.
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(1, 0) == 1 && !m_full) begin
                tx_data = 8'($urandom);
                push(tx_data);
                m_push(tx_data);
            end
            if (m_full && $urandom_range(2, 0) == 0) begin
                @(negedge clk);
                tx_data  = 8'($urandom);
                tx_valid = 1'b1;
                chk("rand_full_ready", {31'd0, tx_ready}, 32'd0);
                @(negedge clk);
                tx_valid = 1'b0;
            end
            run_frame("rand", 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
